// File: rtl/qq_pkg.sv
// Shared types and default sizes for the QuickQ operation scheduler.
// The optional statistics block is controlled by the QQ_STATS_EN macro in qq_op_scheduler.
package qq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        FLUSH
    } qq_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ENQ,
        OP_DEQ
    } qq_op_t;

    localparam int unsigned QQ_KEYW  = 32;
    localparam int unsigned QQ_DEPTH = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps,
// returning a one-hot grant for the first asserted request.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o
);

    localparam int unsigned PtrW = $clog2(NREQ);
    localparam int unsigned IdxW = PtrW + 1;

    logic [IdxW-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // One extra bit so ptr+i cannot overflow before the wrap.
            idx = {1'b0, ptr_i} + IdxW'(i);
            if (idx >= IdxW'(NREQ)) begin
                idx = idx - IdxW'(NREQ);
            end
            if (!found && req_i[idx[PtrW-1:0]]) begin
                gnt_o[idx[PtrW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qq_op_scheduler.sv
// Round-robin enqueue/dequeue scheduler in front of the QuickQ root node.
// Define QQ_STATS_EN to add saturating issue/block statistics counters.
module qq_op_scheduler
    import qq_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned KEYW      = QQ_KEYW,
    parameter int unsigned DEPTH     = QQ_DEPTH,
    parameter int unsigned ISSUE_GAP = 2,
    parameter int unsigned DEQ_LAT   = 3
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [NREQ-1:0]            req_enq_i,
    input  logic [NREQ-1:0]            req_deq_i,
    input  logic [NREQ*KEYW-1:0]       req_key_i,
    output logic [NREQ-1:0]            req_gnt_o,
    output logic                       enq_o,
    output logic                       deq_o,
    output logic [KEYW-1:0]            data_o,
    input  logic [KEYW-1:0]            root_data_i,
    output logic                       node_reset_o,
    output logic                       rsp_valid_o,
    output logic [$clog2(NREQ)-1:0]    rsp_id_o,
    output logic [KEYW-1:0]            rsp_key_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
`ifdef QQ_STATS_EN
    ,
    output logic [31:0]                stat_enq_o,
    output logic [31:0]                stat_deq_o,
    output logic [31:0]                stat_block_o
`endif
);

    localparam int unsigned IdW     = $clog2(NREQ);
    localparam int unsigned CntW    = $clog2(DEPTH + 1);
    localparam int unsigned GapW    = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP - 1) : 1;
    localparam int unsigned GapInit = (ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0;

    qq_state_t        state_q, state_d;
    logic [IdW-1:0]   ptr_q;
    logic [CntW-1:0]  count_q;
    logic [GapW-1:0]  gap_q;
    logic             full, empty;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt_raw;
    logic             granted;
    logic [IdW-1:0]   gnt_idx;
    qq_op_t           op_sel;
    logic             kill;

    logic             enq_q, deq_q;
    logic [KEYW-1:0]  data_q;
    logic [IdW-1:0]   issue_id_q;

    logic [DEQ_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [IdW-1:0]     pipe_id_q [DEQ_LAT];
    logic [IdW-1:0]     pipe_id_d [DEQ_LAT];

    logic             rsp_valid_q;
    logic [IdW-1:0]   rsp_id_q;
    logic [KEYW-1:0]  rsp_key_q;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign kill  = flush_i || (state_q == FLUSH);

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            elig[r] = (req_enq_i[r] && !full) || (req_deq_i[r] && !empty);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt_raw)
    );

    assign granted = |req_gnt_o;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_gnt_o[i]) begin
                gnt_idx = IdW'(i);
            end
        end
    end

    // A requester asking for both gets its dequeue first; the enqueue stays pending.
    always_comb begin
        op_sel = OP_NONE;
        if (granted) begin
            op_sel = (req_deq_i[gnt_idx] && !empty) ? OP_DEQ : OP_ENQ;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                IDLE:    if (granted && (ISSUE_GAP > 1)) state_d = GAP;
                GAP:     if (gap_q == '0) state_d = IDLE;
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        req_gnt_o    = '0;
        node_reset_o = reset_i;
        unique case (state_q)
            IDLE:    if (!flush_i && !reset_i) req_gnt_o = gnt_raw;
            FLUSH:   node_reset_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            gap_q <= '0;
        end else if (state_d == GAP && state_q != GAP) begin
            gap_q <= GapW'(GapInit);
        end else if (state_q == GAP && gap_q != '0) begin
            gap_q <= gap_q - GapW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            if (granted) begin
                ptr_q <= (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + IdW'(1);
            end
            if (kill) begin
                count_q <= '0;
            end else if (op_sel == OP_ENQ) begin
                count_q <= count_q + CntW'(1);
            end else if (op_sel == OP_DEQ) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            enq_q      <= 1'b0;
            deq_q      <= 1'b0;
            data_q     <= '0;
            issue_id_q <= '0;
        end else begin
            enq_q      <= (op_sel == OP_ENQ);
            deq_q      <= (op_sel == OP_DEQ);
            data_q     <= (op_sel == OP_ENQ) ? req_key_i[gnt_idx*KEYW +: KEYW] : '0;
            issue_id_q <= gnt_idx;
        end
    end

    // Response tracker: follows each issued dequeue until its key appears on root_data_i.
    always_comb begin
        pipe_vld_d   = '0;
        pipe_id_d[0] = issue_id_q;
        if (!kill) begin
            pipe_vld_d[0] = deq_q;
        end
        for (int i = 1; i < DEQ_LAT; i++) begin
            pipe_id_d[i] = pipe_id_q[i-1];
            if (!kill) begin
                pipe_vld_d[i] = pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < DEQ_LAT; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_key_q   <= '0;
        end else begin
            rsp_valid_q <= !kill && pipe_vld_q[DEQ_LAT-1];
            if (!kill && pipe_vld_q[DEQ_LAT-1]) begin
                rsp_id_q  <= pipe_id_q[DEQ_LAT-1];
                rsp_key_q <= root_data_i;
            end
        end
    end

    assign enq_o       = enq_q;
    assign deq_o       = deq_q;
    assign data_o      = data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_key_o   = rsp_key_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;

`ifdef QQ_STATS_EN
    logic [31:0] stat_enq_q, stat_deq_q, stat_block_q;
    logic        blocked;

    // Someone is waiting in IDLE but full/empty masking removed every request.
    assign blocked = (state_q == IDLE) && !flush_i && (|(req_enq_i | req_deq_i)) && !(|elig);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_enq_q   <= '0;
            stat_deq_q   <= '0;
            stat_block_q <= '0;
        end else begin
            if (enq_q && stat_enq_q != '1) begin
                stat_enq_q <= stat_enq_q + 32'd1;
            end
            if (deq_q && stat_deq_q != '1) begin
                stat_deq_q <= stat_deq_q + 32'd1;
            end
            if (blocked && stat_block_q != '1) begin
                stat_block_q <= stat_block_q + 32'd1;
            end
        end
    end

    assign stat_enq_o   = stat_enq_q;
    assign stat_deq_o   = stat_deq_q;
    assign stat_block_o = stat_block_q;
`endif

endmodule

// File: tb/tb_qq_op_scheduler.sv
// Bench for qq_op_scheduler: directed scenarios plus a timestamp-based reference model
// compared against the DUT on every cycle.
module tb_qq_op_scheduler;

    localparam int NREQ      = 4;
    localparam int KEYW      = 32;
    localparam int DEPTH     = 64;
    localparam int ISSUE_GAP = 2;
    localparam int DEQ_LAT   = 3;

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  flush_i = 1'b0;
    logic [NREQ-1:0]       req_enq_i = '0;
    logic [NREQ-1:0]       req_deq_i = '0;
    logic [NREQ*KEYW-1:0]  req_key_i = '0;
    logic [NREQ-1:0]       req_gnt_o;
    logic                  enq_o, deq_o;
    logic [KEYW-1:0]       data_o;
    logic [KEYW-1:0]       root_data_i = '0;
    logic                  node_reset_o;
    logic                  rsp_valid_o;
    logic [1:0]            rsp_id_o;
    logic [KEYW-1:0]       rsp_key_o;
    logic [6:0]            count_o;
    logic                  full_o, empty_o;
`ifdef QQ_STATS_EN
    logic [31:0]           stat_enq_o, stat_deq_o, stat_block_o;
`endif

    qq_op_scheduler #(
        .NREQ      (NREQ),
        .KEYW      (KEYW),
        .DEPTH     (DEPTH),
        .ISSUE_GAP (ISSUE_GAP),
        .DEQ_LAT   (DEQ_LAT)
    ) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .req_enq_i    (req_enq_i),
        .req_deq_i    (req_deq_i),
        .req_key_i    (req_key_i),
        .req_gnt_o    (req_gnt_o),
        .enq_o        (enq_o),
        .deq_o        (deq_o),
        .data_o       (data_o),
        .root_data_i  (root_data_i),
        .node_reset_o (node_reset_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_key_o    (rsp_key_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
`ifdef QQ_STATS_EN
        ,
        .stat_enq_o   (stat_enq_o),
        .stat_deq_o   (stat_deq_o),
        .stat_block_o (stat_block_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] key_of(input int c);
        return 32'hA500_0000 + 32'(c);
    endfunction

    // The root node is modelled as presenting a cycle-stamped key every cycle.
    always @(negedge clk) root_data_i = key_of(cyc);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] key;
    } rsp_t;

    rsp_t            rq[$];
    rsp_t            rnew;
    int              m_cnt = 0;
    int              m_ptr = 0;
    int              m_next_idle = 0;
    bit              m_flush_st = 0;
    bit              m_exp_enq = 0, m_exp_deq = 0;
    logic [31:0]     m_exp_data = '0;
    int              m_exp_id = 0;
    int              g, r;
    bit              idle_now, is_deq;
    logic [NREQ-1:0] e_gnt;
`ifdef QQ_STATS_EN
    int              m_st_enq = 0, m_st_deq = 0, m_st_blk = 0;
`endif

    always @(negedge clk) begin
        if (cyc >= 1) begin
            e_gnt    = '0;
            g        = -1;
            idle_now = !reset_i && !m_flush_st && (cyc >= m_next_idle);
            if (idle_now && !flush_i) begin
                for (int i = 0; i < NREQ; i++) begin
                    r = (m_ptr + i) % NREQ;
                    if (g < 0 && ((req_enq_i[r] && m_cnt < DEPTH) || (req_deq_i[r] && m_cnt > 0)))
                        g = r;
                end
                if (g >= 0) e_gnt[g] = 1'b1;
            end
            check("m_gnt", 64'(req_gnt_o), 64'(e_gnt));
            check("m_node_reset", 64'(node_reset_o), 64'(reset_i || m_flush_st));
            check("m_enq", 64'(enq_o), 64'(m_exp_enq));
            check("m_deq", 64'(deq_o), 64'(m_exp_deq));
            if (m_exp_enq) check("m_data", 64'(data_o), 64'(m_exp_data));
            check("m_count", 64'(count_o), 64'(m_cnt));
            check("m_full", 64'(full_o), 64'(m_cnt == DEPTH));
            check("m_empty", 64'(empty_o), 64'(m_cnt == 0));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                check("m_rsp_valid", 64'(rsp_valid_o), 64'(1));
                check("m_rsp_id", 64'(rsp_id_o), 64'(rq[0].id));
                check("m_rsp_key", 64'(rsp_key_o), 64'(rq[0].key));
                void'(rq.pop_front());
            end else begin
                check("m_rsp_valid", 64'(rsp_valid_o), 64'(0));
            end
`ifdef QQ_STATS_EN
            check("m_stat_enq", 64'(stat_enq_o), 64'(m_st_enq));
            check("m_stat_deq", 64'(stat_deq_o), 64'(m_st_deq));
            check("m_stat_block", 64'(stat_block_o), 64'(m_st_blk));
`endif
            // advance to the next cycle
            if (reset_i) begin
                m_cnt = 0; m_ptr = 0; m_next_idle = cyc + 1; m_flush_st = 0;
                rq.delete();
                m_exp_enq = 0; m_exp_deq = 0;
`ifdef QQ_STATS_EN
                m_st_enq = 0; m_st_deq = 0; m_st_blk = 0;
`endif
            end else begin
`ifdef QQ_STATS_EN
                if (m_exp_enq) m_st_enq++;
                if (m_exp_deq) m_st_deq++;
                if (idle_now && !flush_i && (|(req_enq_i | req_deq_i)) && g < 0) m_st_blk++;
`endif
                if (flush_i) begin
                    m_cnt = 0; m_next_idle = cyc + 2; m_flush_st = 1;
                    rq.delete();
                    m_exp_enq = 0; m_exp_deq = 0;
                end else begin
                    m_flush_st = 0;
                    if (m_exp_deq) begin
                        rnew.due = cyc + DEQ_LAT + 1;
                        rnew.id  = m_exp_id;
                        rnew.key = key_of(cyc + DEQ_LAT);
                        rq.push_back(rnew);
                    end
                    m_exp_enq = 0; m_exp_deq = 0;
                    if (g >= 0) begin
                        is_deq = req_deq_i[g] && m_cnt > 0;
                        m_exp_deq  = is_deq;
                        m_exp_enq  = !is_deq;
                        m_exp_data = req_key_i[g*KEYW +: KEYW];
                        m_exp_id   = g;
                        m_cnt      = is_deq ? m_cnt - 1 : m_cnt + 1;
                        m_ptr      = (g + 1) % NREQ;
                        m_next_idle = cyc + ISSUE_GAP;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name, output logic [NREQ-1:0] gv, output int gc);
        bit done = 0;
        gv = '0;
        gc = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (|req_gnt_o) begin
                gv = req_gnt_o;
                gc = cyc;
                done = 1;
            end else begin
                tick();
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: no grant within 40 cycles", name);
        end
    endtask

    logic [NREQ-1:0] gv1, gv2;
    int              t, t2, n;
    int              gidx[8];
    int              gcy[8];
    bit              rsp_seen;

    initial begin
        repeat (3) tick();
        check("rst_node_reset", 64'(node_reset_o), 64'(1));
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_empty", 64'(empty_o), 64'(1));
        reset_i = 1'b0;

        // single enqueue from requester 0
        tick();
        req_enq_i = 4'b0001;
        req_key_i[0 +: 32] = 32'h10;
        #1;
        check("enq0_gnt", 64'(req_gnt_o), 64'(4'b0001));
        tick();
        req_enq_i = '0;
        check("enq0_enq_o", 64'(enq_o), 64'(1));
        check("enq0_data_o", 64'(data_o), 64'(32'h10));
        check("enq0_count", 64'(count_o), 64'(1));

        // dequeue by requester 2 with one key stored
        tick();
        req_deq_i = 4'b0100;
        #1;
        check("deq2_gnt", 64'(req_gnt_o), 64'(4'b0100));
        t = cyc;
        tick();
        req_deq_i = '0;
        check("deq2_deq_o", 64'(deq_o), 64'(1));
        check("deq2_empty", 64'(empty_o), 64'(1));
        repeat (3) tick();
        check("deq2_no_early_rsp", 64'(rsp_valid_o), 64'(0));
        tick();
        check("deq2_rsp_valid", 64'(rsp_valid_o), 64'(1));
        check("deq2_rsp_id", 64'(rsp_id_o), 64'(2));
        check("deq2_rsp_key", 64'(rsp_key_o), 64'(key_of(t + 4)));

        // reset returns the pointer to 0
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("rst2_count", 64'(count_o), 64'(0));

        // all four requesters enqueue continuously
        for (int i = 0; i < NREQ; i++) req_key_i[i*32 +: 32] = 32'h100 + 32'(i);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) req_enq_i = 4'b1111;
            #1;
            if (|req_gnt_o && n < 8) begin
                for (int i = 0; i < NREQ; i++) if (req_gnt_o[i]) gidx[n] = i;
                gcy[n] = cyc;
                n++;
            end
        end
        req_enq_i = '0;
        check("rr_grants", 64'(n), 64'(5));
        for (int i = 0; i < 5 && i < n; i++) begin
            check("rr_order", 64'(gidx[i]), 64'(i % 4));
            if (i > 0) check("rr_spacing", 64'(gcy[i] - gcy[i-1]), 64'(2));
        end

        // fill to capacity
        req_enq_i = 4'b0001;
        n = 0;
        while (count_o != 7'd64 && n < 300) begin
            tick();
            n++;
        end
        req_enq_i = '0;
        check("fill_count", 64'(count_o), 64'(64));
        check("fill_full", 64'(full_o), 64'(1));

        // full: enq from 1 is masked, deq from 3 goes first
        req_enq_i = 4'b0010;
        req_deq_i = 4'b1000;
        wait_gnt("full_first", gv1, t);
        tick();
        req_enq_i &= ~gv1;
        req_deq_i &= ~gv1;
        wait_gnt("full_second", gv2, t2);
        tick();
        req_enq_i &= ~gv2;
        req_deq_i &= ~gv2;
        check("full_first_gnt", 64'(gv1), 64'(4'b1000));
        check("full_second_gnt", 64'(gv2), 64'(4'b0010));
        check("full_count_after", 64'(count_o), 64'(64));

        // flush with a dequeue in flight
        req_deq_i = 4'b0001;
        wait_gnt("flush_deq", gv1, t);
        tick();
        req_deq_i = '0;
        check("flush_deq_o", 64'(deq_o), 64'(1));
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_node_reset", 64'(node_reset_o), 64'(1));
        check("flush_count", 64'(count_o), 64'(0));
        check("flush_empty", 64'(empty_o), 64'(1));
        tick();
        check("flush_node_reset_end", 64'(node_reset_o), 64'(0));
        rsp_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid_o) rsp_seen = 1;
            tick();
        end
        check("flush_no_rsp", 64'(rsp_seen), 64'(0));

`ifdef QQ_STATS_EN
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        req_deq_i = 4'b0001;
        repeat (10) tick();
        req_deq_i = '0;
        #1;
        check("stat_block", 64'(stat_block_o), 64'(10));
        check("stat_deq", 64'(stat_deq_o), 64'(0));
`endif

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
